i2c_clk_init: RTL and testbench

- Power-on I2C master that programs the SFP reference clock synthesiser (Si5324) through the board I2C mux (PCA9548) before Ethernet bring-up.
- Sits upstream of the Ethernet top: its `done` output gates release of the Ethernet reset, so the SFP clock is stable before `eth_top` leaves reset.
- Register contents come from an external 16-bit ROM supplied by the top level. The block drives the shared `I2C_FPGA_SCL`/`I2C_FPGA_SDA` pins through top-level IOBUFs using open-drain tristate controls.

---
 rtl/i2c_clk_init.sv | 184 ++++++++++++++++++
 tb/tb_i2c_clk_init.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_clk_init.sv
// Power-on I2C master: selects the SFP channel on the PCA9548 mux, then writes
// NUM_WR register/value pairs from an external ROM into the Si5324.
module i2c_clk_init #(
  parameter int unsigned CLK_HZ    = 200000000,
  parameter int unsigned I2C_HZ    = 100000,
  parameter logic [6:0]  MUX_ADDR  = 7'h74,
  parameter logic [7:0]  MUX_CHAN  = 8'h10,
  parameter logic [6:0]  DEV_ADDR  = 7'h68,
  parameter int unsigned NUM_WR    = 43,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned AW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  logic          clk200,
  input  logic          rst_n,
  input  logic          start,
  output logic          scl_t,
  output logic          sda_t,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int unsigned QDIV = CLK_HZ / (4 * I2C_HZ);
  localparam int unsigned DW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int unsigned TW   = $clog2(NUM_WR + 1);
  localparam int unsigned RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_TXBYTE, S_STOP, S_GAP, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q;
  logic [1:0]    phase_q;
  logic [3:0]    bit_q;
  logic [1:0]    byte_q;
  logic [TW-1:0] txn_q;
  logic [RW-1:0] retry_q;
  logic          nack_q;
  logic [15:0]   rom_q;
  logic [7:0]    cur_byte;
  logic          active, stretch, tick, phase_end, last_byte;
  logic          scl_lvl, sda_lvl;

  assign active    = (state_q == S_START) || (state_q == S_TXBYTE) ||
                     (state_q == S_STOP)  || (state_q == S_GAP);
  // Slave holds SCL low after we released it: freeze divider and phase.
  assign stretch   = active && ((phase_q == 2'd1) || (phase_q == 2'd2)) && scl_t && !scl_i;
  assign tick      = active && !stretch && (div_q == DW'(QDIV - 1));
  assign phase_end = tick && (phase_q == 2'd3);
  assign last_byte = (txn_q == '0) ? (byte_q == 2'd1) : (byte_q == 2'd2);

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = (txn_q == '0) ? {MUX_ADDR, 1'b0} : {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = (txn_q == '0) ? MUX_CHAN : rom_q[15:8];
      default: cur_byte = rom_q[7:0];
    endcase
  end

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_START;
      S_START:  if (phase_end) state_d = S_TXBYTE;
      S_TXBYTE: if (phase_end && (bit_q == 4'd8) && (nack_q || last_byte)) state_d = S_STOP;
      S_STOP:   if (phase_end) state_d = S_GAP;
      S_GAP:    if (phase_end) state_d = S_NEXT;
      S_NEXT: begin
        if (nack_q)                    state_d = (retry_q < RW'(MAX_RETRY)) ? S_START : S_ERR;
        else if (txn_q == TW'(NUM_WR)) state_d = S_DONE;
        else                           state_d = S_START;
      end
      S_DONE:   state_d = S_DONE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus levels per phase; each phase step moves at most one line.
  always_comb begin
    scl_lvl = 1'b1;
    sda_lvl = 1'b1;
    case (state_q)
      S_START: begin
        scl_lvl = (phase_q != 2'd3);
        sda_lvl = (phase_q < 2'd2);
      end
      S_TXBYTE: begin
        scl_lvl = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_lvl = (bit_q == 4'd8) ? 1'b1 : cur_byte[3'(4'd7 - bit_q)];
      end
      S_STOP: begin
        scl_lvl = (phase_q != 2'd0);
        sda_lvl = (phase_q >= 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= '0;
    end else if (!active) begin
      div_q   <= '0;
      phase_q <= '0;
    end else if (!stretch) begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) phase_q <= phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      bit_q  <= '0;
      byte_q <= '0;
      nack_q <= 1'b0;
      rom_q  <= '0;
    end else begin
      if (state_q == S_START) begin
        bit_q  <= '0;
        byte_q <= '0;
        rom_q  <= rom_data;
      end else if ((state_q == S_TXBYTE) && phase_end) begin
        if (bit_q == 4'd8) begin
          bit_q  <= '0;
          byte_q <= byte_q + 1'b1;
        end else begin
          bit_q <= bit_q + 1'b1;
        end
      end
      if (state_q == S_NEXT)
        nack_q <= 1'b0;
      else if ((state_q == S_TXBYTE) && tick && (phase_q == 2'd2) && (bit_q == 4'd8) && sda_i)
        nack_q <= 1'b1;
    end
  end

  // Transaction sequencing and retry bookkeeping, all resolved in NEXT.
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      txn_q    <= '0;
      retry_q  <= '0;
      rom_addr <= '0;
    end else if (state_q == S_NEXT) begin
      if (nack_q) begin
        if (retry_q < RW'(MAX_RETRY)) retry_q <= retry_q + 1'b1;
      end else begin
        retry_q <= '0;
        if (txn_q != TW'(NUM_WR)) begin
          txn_q    <= txn_q + 1'b1;
          rom_addr <= AW'(txn_q);
        end
      end
    end
  end

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      scl_t <= 1'b1;
      sda_t <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      scl_t <= scl_lvl;
      sda_t <= sda_lvl;
      busy  <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
      done  <= (state_d == S_DONE);
      error <= (state_d == S_ERR);
    end
  end

endmodule

// File: tb/tb_i2c_clk_init.sv
// Bench for i2c_clk_init: open-drain bus model with a logging slave that can
// NACK or stretch SCL, table of scenarios plus hand-written reset sequences.
module tb_i2c_clk_init;

  localparam int unsigned NUM_WR    = 3;
  localparam int unsigned QDIV      = 10;
  localparam int          EXP_RISES = 9 * (2 + 3 * NUM_WR);
  localparam int          STR_LEN   = 3000;
  localparam int          LIMIT     = 40000;

  typedef struct {
    int nack_mode;  // 0 ack all, 1 nack all, 2 nack T2 address once
    bit stretch;
    bit exp_done;
    bit exp_err;
  } row_t;

  logic        clk200 = 1'b0;
  logic        rst_n  = 1'b1;
  logic        start  = 1'b0;
  logic        scl_t, sda_t, busy, done, error;
  logic        scl_line, sda_line;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data;

  int  nvec = 0, nerr = 0;
  int  nack_mode = 0;
  bit  stretch_en = 1'b0;
  bit  mon_clr = 1'b0;

  int  bitcnt, nbytes, start_cnt, stop_cnt, stretch_cnt;
  int  n40, nbad, both_chg, chg, hi_cnt, cyc, last_rise;
  bit  last_valid, in_txn, ack_drv, nacked_once, stretched_once, rst_seen;
  bit  prev_scl, prev_sda, p_scl_t, p_sda_t;
  logic [7:0]  sh, b0, b1, b2;
  logic [31:0] log_q[$];
  logic [31:0] exp_q[$];
  logic        nack_now;
  row_t        rows[4];

  always #5 clk200 = ~clk200;

  assign scl_line = scl_t & (stretch_cnt == 0);
  assign sda_line = sda_t & ~ack_drv;
  assign nack_now = (nack_mode == 1) ||
                    ((nack_mode == 2) && !nacked_once && (start_cnt == 3) && (nbytes == 0));

  i2c_clk_init #(.CLK_HZ(4 * QDIV * 100), .I2C_HZ(100), .NUM_WR(NUM_WR)) dut (
    .clk200(clk200), .rst_n(rst_n), .start(start),
    .scl_t(scl_t), .sda_t(sda_t), .scl_i(scl_line), .sda_i(sda_line),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .error(error)
  );

  function automatic logic [15:0] rom_val(input logic [1:0] a);
    case (a)
      2'd0:    return 16'h8A3C;
      2'd1:    return 16'h1B55;
      2'd2:    return 16'h8837;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk200) rom_data <= rom_val(rom_addr);

  // Bus monitor and slave, sampled on the inactive edge.
  always @(negedge clk200) begin
    prev_scl <= scl_line;
    prev_sda <= sda_line;
    p_scl_t  <= scl_t;
    p_sda_t  <= sda_t;
    cyc      <= cyc + 1;
    if (stretch_cnt != 0) stretch_cnt <= stretch_cnt - 1;
    if (mon_clr) begin
      log_q.delete();
      bitcnt <= 0; nbytes <= 0; start_cnt <= 0; stop_cnt <= 0; stretch_cnt <= 0;
      n40 <= 0; nbad <= 0; both_chg <= 0; chg <= 0; hi_cnt <= 0;
      last_valid <= 1'b0; in_txn <= 1'b0; ack_drv <= 1'b0;
      nacked_once <= 1'b0; stretched_once <= 1'b0; rst_seen <= 1'b1;
    end else if (!rst_n) begin
      bitcnt <= 0; ack_drv <= 1'b0; stretch_cnt <= 0; in_txn <= 1'b0; rst_seen <= 1'b1;
    end else begin
      rst_seen <= 1'b0;
      if (!rst_seen && (scl_t != p_scl_t) && (sda_t != p_sda_t)) both_chg <= both_chg + 1;
      if (scl_t && !p_scl_t) begin
        if (last_valid) begin
          if ((cyc - last_rise >= 39) && (cyc - last_rise <= 41)) n40 <= n40 + 1;
          else if (cyc - last_rise < 100) nbad <= nbad + 1;
        end
        last_rise  <= cyc;
        last_valid <= 1'b1;
      end
      if ((stretch_cnt != 0) && scl_t) hi_cnt <= hi_cnt + 1;
      if ((stretch_cnt != 0) && p_scl_t && ((scl_t != p_scl_t) || (sda_t != p_sda_t)))
        chg <= chg + 1;
      if (scl_line && prev_scl && prev_sda && !sda_line) begin
        bitcnt <= 0; nbytes <= 0; ack_drv <= 1'b0; in_txn <= 1'b1;
        b0 <= '0; b1 <= '0; b2 <= '0;
        start_cnt <= start_cnt + 1;
      end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
        if (in_txn) log_q.push_back({8'(nbytes), b0, b1, b2});
        stop_cnt <= stop_cnt + 1;
        in_txn   <= 1'b0;
      end else if (scl_line && !prev_scl) begin
        if (bitcnt < 8) begin
          sh     <= {sh[6:0], sda_line};
          bitcnt <= bitcnt + 1;
          if (bitcnt == 7) begin
            if (nbytes == 0)      b0 <= {sh[6:0], sda_line};
            else if (nbytes == 1) b1 <= {sh[6:0], sda_line};
            else if (nbytes == 2) b2 <= {sh[6:0], sda_line};
          end
        end
      end else if (!scl_line && prev_scl) begin
        if (bitcnt == 8) begin
          ack_drv <= !nack_now;
          bitcnt  <= 9;
          if (nack_now && (nack_mode == 2)) nacked_once <= 1'b1;
        end else if (bitcnt == 9) begin
          ack_drv <= 1'b0;
          bitcnt  <= 0;
          nbytes  <= nbytes + 1;
        end else if (stretch_en && !stretched_once && (start_cnt == 2) && (nbytes == 0) && (bitcnt == 4)) begin
          stretch_cnt    <= STR_LEN;
          stretched_once <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic build_exp(input int mode);
    exp_q.delete();
    if (mode == 1) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({8'd1, 8'hE8, 16'h0000});
    end else begin
      exp_q.push_back({8'd2, 8'hE8, 8'h10, 8'h00});
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if ((mode == 2) && (k == 1)) exp_q.push_back({8'd1, 8'hD0, 16'h0000});
        exp_q.push_back({8'd3, 8'hD0, rom_val(2'(k))});
      end
    end
  endtask

  task automatic do_reset(input bit st);
    start   = 1'b0;
    rst_n   = 1'b0;
    mon_clr = 1'b1;
    repeat (3) @(negedge clk200);
    mon_clr = 1'b0;
    @(posedge clk200);
    #1 rst_n = 1'b1;
    start = st;
  endtask

  task automatic wait_end(input string nm);
    int n = 0;
    while (!(done || error) && (n < LIMIT)) begin
      @(posedge clk200);
      n++;
    end
    repeat (20) @(posedge clk200);
    @(negedge clk200);
    chk(nm, 32'(n >= LIMIT), 32'd0);
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int k = 0; (k < exp_q.size()) && (k < log_q.size()); k++)
      chk($sformatf("%s_txn%0d", nm, k), log_q[k], exp_q[k]);
  endtask

  initial begin
    rows[0] = '{0, 1'b0, 1'b1, 1'b0};
    rows[1] = '{2, 1'b0, 1'b1, 1'b0};
    rows[2] = '{1, 1'b0, 1'b0, 1'b1};
    rows[3] = '{0, 1'b1, 1'b1, 1'b0};

    // Reset state, start held low.
    do_reset(1'b0);
    repeat (50) @(negedge clk200);
    chk("rst_scl_t", 32'(scl_t), 32'd1);
    chk("rst_sda_t", 32'(sda_t), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);

    for (int i = 0; i < 4; i++) begin
      nack_mode  = rows[i].nack_mode;
      stretch_en = rows[i].stretch;
      build_exp(rows[i].nack_mode);
      do_reset(1'b1);
      wait_end($sformatf("row%0d_timeout", i));
      chk($sformatf("row%0d_done", i), 32'(done), 32'(rows[i].exp_done));
      chk($sformatf("row%0d_error", i), 32'(error), 32'(rows[i].exp_err));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'd0);
      chk($sformatf("row%0d_scl_rel", i), 32'(scl_t), 32'd1);
      chk($sformatf("row%0d_sda_rel", i), 32'(sda_t), 32'd1);
      chk($sformatf("row%0d_both_edge", i), 32'(both_chg), 32'd0);
      chk_log($sformatf("row%0d", i));
      if (i == 0) begin
        chk("scl_period_count", 32'(n40), 32'(EXP_RISES));
        chk("scl_period_bad", 32'(nbad), 32'd0);
        chk("start_count", 32'(start_cnt), 32'd4);
        chk("stop_count", 32'(stop_cnt), 32'd4);
      end
      if (rows[i].stretch) begin
        chk("stretch_changes", 32'(chg), 32'd0);
        chk("stretch_scl_held", 32'(hi_cnt >= STR_LEN - 3 * int'(QDIV)), 32'd1);
      end
    end

    // Reset during T1 data bit 3, then restart with start held high.
    nack_mode  = 0;
    stretch_en = 1'b0;
    build_exp(0);
    do_reset(1'b1);
    begin
      int n = 0;
      while (!((start_cnt == 2) && (bitcnt == 3) && !scl_line) && (n < LIMIT)) begin
        @(negedge clk200);
        #1;
        n++;
      end
      chk("midbyte_reach_timeout", 32'(n >= LIMIT), 32'd0);
    end
    chk("pre_reset_scl_low", 32'(scl_t), 32'd0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_scl_t", 32'(scl_t), 32'd1);
    chk("midrst_sda_t", 32'(sda_t), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    mon_clr = 1'b1;
    repeat (3) @(negedge clk200);
    mon_clr = 1'b0;
    @(posedge clk200);
    #1 rst_n = 1'b1;
    wait_end("restart_timeout");
    chk("restart_done", 32'(done), 32'd1);
    chk("restart_error", 32'(error), 32'd0);
    chk_log("restart");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
